pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipelined, parametrised control unit for the five-stage processor. It decodes the instruction held in the decode stage and carries the resulting control word through registered EX, MEM and WB stages. It generates stall and bubble behaviour for load-use hazards and multi-cycle mul/div operations. It also resolves the rstatus exception writes (codes 1–5) in WB.

## Interface
- OPW, 5: opcode and ALU-op field width
- REGW, 5: register index width
- DATA_W, 32: width of the rstatus value
- STATUS_REG, 30: index written on exception and setx
- LINK_REG, 31: index written by jal

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- id_valid  in  1  decode stage holds a real instruction
- id_opcode  in  OPW  instruction opcode
- id_aluop  in  OPW  ALU op field (R-type only)
- id_rd, id_rs, id_rt  in  REGW  register fields
- br_taken  in  1  branch/jump in EX resolved taken
- alu_ovf  in  1  ALU overflow for the instruction in EX
- md_ready  in  1  mul/div result valid, 1-cycle pulse
- md_exc  in  1  mul/div exception, qualified by md_ready
- stall  out  1  freeze PC and F/D register
- md_start  out  1  1-cycle start pulse to mul/div unit
- md_is_div  out  1  operation select for md_start
- ex_valid, ex_alu_imm, ex_md  out  1  EX control: ALU B = immediate; mul/div op
- ex_aluop  out  OPW  ALU op to EX (00000 add for addi/lw/sw; 00001 sub for bne/blt)
- mem_valid, mem_we  out  1  MEM control; mem_we for sw
- wb_valid, wb_we, wb_sel_mem  out  1  WB control; wb_sel_mem for lw
- wb_rd  out  REGW  WB destination
- wb_status_we  out  1  exception write to rstatus
- wb_status  out  DATA_W  rstatus value

## Operation
- Decode classes by opcode:
  - R-type 00000
  - j 00001
  - bne 00010
  - jal 00011
  - jr 00100
  - addi 00101
  - blt 00110
  - sw 00111
  - lw 01000
  - setx 10101
  - bex 10110
- R-type subclasses by ALU op: mul 00110, div 00111. All other opcodes decode as NOP.
- Register write enable is set for R-type, addi, lw, jal and setx.
  - Destination is id_rd, except jal (LINK_REG) and setx (STATUS_REG).
  - Any write with destination 0 is suppressed.
- Sources for hazard checks:
  - R-type: rs, rt
  - addi, lw: rs
  - sw, bne, blt: rd, rs
  - jr: rd
  - bex: STATUS_REG
- Load-use hazard: EX holds a valid lw with nonzero destination equal to any ID source.
  - stall=1 for one cycle.
  - A bubble (ex_valid=0) enters EX; the ID instruction is held.
- Flush: br_taken=1 turns the ID instruction into a bubble at the next edge. Flush overrides load-use stall.
- Mul/div FSM has two states, MD_IDLE and MD_BUSY.
  - IDLE→BUSY when a valid mul/div enters EX; md_start=1 during its first EX cycle.
  - In BUSY: stall=1, and EX, ID and PC are frozen. MEM receives bubbles.
  - BUSY→IDLE on md_ready; the mul/div advances to MEM at that edge.
- Status codes: add 1, addi 2, sub 3, mul 4, div 5.
  - Captured in EX on alu_ovf (add/addi/sub) or md_exc (mul/div).
  - In WB: wb_status_we=1, wb_rd=STATUS_REG and wb_status=code. The normal result write is replaced.
- setx: wb_status_we=0; a normal write to STATUS_REG.
- Widths: wb_status is zero-extended to DATA_W; no other arithmetic.

## Timing
- An instruction decoded in cycle N is in EX at N+1, MEM at N+2 and WB at N+3 when no stall occurs.
- Reset (async, low): every output is 0 and the FSM is in MD_IDLE.
  - Asserting reset mid-mul/div aborts it; md_ready arriving after reset is ignored while IDLE.
- stall is combinational from EX/ID state and FSM state in the same cycle.
- md_start is combinational: high only on the first EX cycle of the mul/div and never re-pulses while BUSY.
- md_ready in the same cycle as md_start is legal: 1-cycle op, no BUSY cycle.
- Simultaneous events:
  - br_taken is never high while BUSY; mul/div is not a branch.
  - Mul/div stall dominates load-use.
  - id_valid=0 produces a bubble with no hazard.

## Test plan
- Independent adds: add r1; add r2 with id_valid=1 in consecutive cycles → wb_valid in cycles 3 and 4, wb_rd=1 then 2, stall never asserted.
- Load-use: lw r5 followed by add r6=r5+r7 → stall=1 for exactly one cycle and ex_valid=0 for one cycle. Repeating with rd=0 on the lw → no stall.
- Mul/div: mul, md_ready held off 4 cycles then pulsed → md_start pulses once, md_is_div=0, stall=1 for 4 cycles, mul reaches WB 2 cycles after md_ready.
- Exceptions: addi with alu_ovf=1 → wb_status_we=1, wb_rd=30, wb_status=2. div with md_exc=1 → wb_status=5. Writes targeting r0 → wb_we=0.
- Flush: bne in EX with br_taken=1 while lw/add load-use pair is pending → no stall and a bubble in EX next cycle. Reset pulsed low while BUSY → all outputs 0 asynchronously and FSM IDLE.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Control pipeline for the five-stage core: decodes the ID instruction, carries
// control through EX/MEM/WB, and handles load-use, mul/div stalls and rstatus exceptions.
module pipe_ctrl #(
    parameter int OPW        = 5,
    parameter int REGW       = 5,
    parameter int DATA_W     = 32,
    parameter int STATUS_REG = 30,
    parameter int LINK_REG   = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [OPW-1:0]    id_opcode,
    input  logic [OPW-1:0]    id_aluop,
    input  logic [REGW-1:0]   id_rd,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              br_taken,
    input  logic              alu_ovf,
    input  logic              md_ready,
    input  logic              md_exc,
    output logic              stall,
    output logic              md_start,
    output logic              md_is_div,
    output logic              ex_valid,
    output logic              ex_alu_imm,
    output logic              ex_md,
    output logic [OPW-1:0]    ex_aluop,
    output logic              mem_valid,
    output logic              mem_we,
    output logic              wb_valid,
    output logic              wb_we,
    output logic              wb_sel_mem,
    output logic [REGW-1:0]   wb_rd,
    output logic              wb_status_we,
    output logic [DATA_W-1:0] wb_status
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(2);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
    localparam logic [OPW-1:0] OP_JR    = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(5);
    localparam logic [OPW-1:0] OP_BLT   = OPW'(6);
    localparam logic [OPW-1:0] OP_SW    = OPW'(7);
    localparam logic [OPW-1:0] OP_LW    = OPW'(8);
    localparam logic [OPW-1:0] OP_SETX  = OPW'(21);
    localparam logic [OPW-1:0] OP_BEX   = OPW'(22);

    localparam logic [OPW-1:0] ALU_ADD = OPW'(0);
    localparam logic [OPW-1:0] ALU_SUB = OPW'(1);
    localparam logic [OPW-1:0] ALU_MUL = OPW'(6);
    localparam logic [OPW-1:0] ALU_DIV = OPW'(7);

    localparam logic [2:0] ST_ADD  = 3'd1;
    localparam logic [2:0] ST_ADDI = 3'd2;
    localparam logic [2:0] ST_SUB  = 3'd3;
    localparam logic [2:0] ST_MUL  = 3'd4;
    localparam logic [2:0] ST_DIV  = 3'd5;

    localparam logic [REGW-1:0] STATUS_IDX = REGW'(STATUS_REG);
    localparam logic [REGW-1:0] LINK_IDX   = REGW'(LINK_REG);

    // code: status value this instruction raises on overflow / mul-div exception
    typedef struct packed {
        logic            valid;
        logic            alu_imm;
        logic            md;
        logic            is_lw;
        logic            mem_we;
        logic            reg_we;
        logic [OPW-1:0]  aluop;
        logic [REGW-1:0] rd;
        logic [2:0]      code;
    } ex_ctrl_t;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    ex_ctrl_t        dec;
    ex_ctrl_t        ex_q;
    md_state_t       md_state;
    logic            dec_we;
    logic [REGW-1:0] dec_dest;
    logic [REGW-1:0] src_a;
    logic [REGW-1:0] src_b;
    logic            use_a;
    logic            use_b;
    logic            load_use;
    logic            md_hold;
    logic            ex_exc;

    logic            mem_reg_we;
    logic            mem_sel_mem;
    logic [REGW-1:0] mem_rd;
    logic            mem_status_we;
    logic [2:0]      mem_code;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no case path leaves one unassigned and infers a latch.
        dec      = '0;
        dec_we   = 1'b0;
        dec_dest = id_rd;
        src_a    = id_rs;
        src_b    = id_rt;
        use_a    = 1'b0;
        use_b    = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                dec_we    = 1'b1;
                use_a     = 1'b1;
                use_b     = 1'b1;
                dec.aluop = id_aluop;
                dec.md    = (id_aluop == ALU_MUL) || (id_aluop == ALU_DIV);
                if (id_aluop == ALU_ADD)      dec.code = ST_ADD;
                else if (id_aluop == ALU_SUB) dec.code = ST_SUB;
                else if (id_aluop == ALU_MUL) dec.code = ST_MUL;
                else if (id_aluop == ALU_DIV) dec.code = ST_DIV;
            end
            OP_BNE, OP_BLT: begin
                dec.aluop = ALU_SUB;
                src_a     = id_rd;
                src_b     = id_rs;
                use_a     = 1'b1;
                use_b     = 1'b1;
            end
            OP_JAL: begin
                dec_we   = 1'b1;
                dec_dest = LINK_IDX;
            end
            OP_JR: begin
                src_a = id_rd;
                use_a = 1'b1;
            end
            OP_ADDI: begin
                dec_we      = 1'b1;
                dec.alu_imm = 1'b1;
                use_a       = 1'b1;
                dec.code    = ST_ADDI;
            end
            OP_SW: begin
                dec.alu_imm = 1'b1;
                dec.mem_we  = 1'b1;
                src_a       = id_rd;
                src_b       = id_rs;
                use_a       = 1'b1;
                use_b       = 1'b1;
            end
            OP_LW: begin
                dec_we      = 1'b1;
                dec.alu_imm = 1'b1;
                dec.is_lw   = 1'b1;
                use_a       = 1'b1;
            end
            OP_SETX: begin
                dec_we   = 1'b1;
                dec_dest = STATUS_IDX;
            end
            OP_BEX: begin
                src_a = STATUS_IDX;
                use_a = 1'b1;
            end
            default: ;  // j and unknown opcodes carry no control
        endcase
        dec.valid  = 1'b1;
        dec.reg_we = dec_we && (dec_dest != '0);
        dec.rd     = dec.reg_we ? dec_dest : '0;
        if (!id_valid) dec = '0;
    end

    assign md_hold  = ex_q.valid && ex_q.md && !md_ready;
    assign load_use = id_valid && ex_q.valid && ex_q.is_lw && ex_q.reg_we &&
                      ((use_a && (src_a == ex_q.rd)) || (use_b && (src_b == ex_q.rd)));
    assign stall    = md_hold || (load_use && !br_taken);

    assign md_start  = ex_q.valid && ex_q.md && (md_state == MD_IDLE);
    assign md_is_div = md_start && (ex_q.aluop == ALU_DIV);

    // md_exc is only consulted when the mul/div actually leaves EX, i.e. with md_ready
    assign ex_exc = ex_q.valid && (ex_q.code != '0) && (ex_q.md ? md_exc : alu_ovf);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_state <= MD_IDLE;
        end else begin
            // NOTE: non-blocking assignment so all state updates see the pre-edge values.
            md_state <= md_hold ? MD_BUSY : MD_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_q          <= '0;
            mem_valid     <= 1'b0;
            mem_we        <= 1'b0;
            mem_reg_we    <= 1'b0;
            mem_sel_mem   <= 1'b0;
            mem_rd        <= '0;
            mem_status_we <= 1'b0;
            mem_code      <= '0;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_sel_mem    <= 1'b0;
            wb_rd         <= '0;
            wb_status_we  <= 1'b0;
            wb_status     <= '0;
        end else begin
            if (!md_hold) ex_q <= (br_taken || load_use) ? '0 : dec;

            if (md_hold) begin
                mem_valid     <= 1'b0;
                mem_we        <= 1'b0;
                mem_reg_we    <= 1'b0;
                mem_sel_mem   <= 1'b0;
                mem_rd        <= '0;
                mem_status_we <= 1'b0;
                mem_code      <= '0;
            end else begin
                mem_valid     <= ex_q.valid;
                mem_we        <= ex_q.mem_we;
                mem_reg_we    <= ex_q.reg_we && !ex_exc;
                mem_sel_mem   <= ex_q.is_lw;
                mem_rd        <= ex_exc ? STATUS_IDX : ex_q.rd;
                mem_status_we <= ex_exc;
                mem_code      <= ex_exc ? ex_q.code : '0;
            end

            wb_valid     <= mem_valid;
            wb_we        <= mem_reg_we;
            wb_sel_mem   <= mem_sel_mem;
            wb_rd        <= mem_rd;
            wb_status_we <= mem_status_we;
            wb_status    <= DATA_W'(mem_code);
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_alu_imm = ex_q.alu_imm;
    assign ex_md      = ex_q.md;
    assign ex_aluop   = ex_q.aluop;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: an instruction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_opcode, id_aluop, id_rd, id_rs, id_rt;
    logic        br_taken, alu_ovf, md_ready, md_exc;
    logic        stall, md_start, md_is_div;
    logic        ex_valid, ex_alu_imm, ex_md;
    logic [4:0]  ex_aluop;
    logic        mem_valid, mem_we;
    logic        wb_valid, wb_we, wb_sel_mem;
    logic [4:0]  wb_rd;
    logic        wb_status_we;
    logic [31:0] wb_status;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clock(clk), .reset(rst_n),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_aluop(id_aluop),
        .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .br_taken(br_taken), .alu_ovf(alu_ovf), .md_ready(md_ready), .md_exc(md_exc),
        .stall(stall), .md_start(md_start), .md_is_div(md_is_div),
        .ex_valid(ex_valid), .ex_alu_imm(ex_alu_imm), .ex_md(ex_md), .ex_aluop(ex_aluop),
        .mem_valid(mem_valid), .mem_we(mem_we),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_sel_mem(wb_sel_mem), .wb_rd(wb_rd),
        .wb_status_we(wb_status_we), .wb_status(wb_status)
    );

    int n_checks = 0;
    int n_errors = 0;

    // One instruction as the specification describes it: what it does, not how it is encoded.
    typedef struct {
        bit       valid;
        bit       md;
        bit       div;
        bit       lw;
        bit       sw;
        bit       imm;
        bit       branch;
        bit       we;
        bit [4:0] aluop;
        bit [4:0] dest;
        bit [4:0] src0;
        bit [4:0] src1;
        int       nsrc;
        int       code;
    } instr_t;

    instr_t m_ex, m_mem, m_wb, cur_id;
    bit     m_mem_exc, m_wb_exc, m_started, m_last_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic instr_t none();
        instr_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic instr_t decode(input bit v, input bit [4:0] op, input bit [4:0] alu,
                                      input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
        instr_t r;
        r = '{default: 0};
        if (!v) return r;
        r.valid = 1'b1;
        case (op)
            5'd0: begin
                r.we = 1'b1; r.dest = rd; r.nsrc = 2; r.src0 = rs; r.src1 = rt; r.aluop = alu;
                r.md  = (alu == 5'd6) || (alu == 5'd7);
                r.div = (alu == 5'd7);
                case (alu)
                    5'd0:    r.code = 1;
                    5'd1:    r.code = 3;
                    5'd6:    r.code = 4;
                    5'd7:    r.code = 5;
                    default: r.code = 0;
                endcase
            end
            5'd1:       r.branch = 1'b1;
            5'd2, 5'd6: begin r.branch = 1'b1; r.aluop = 5'd1; r.nsrc = 2; r.src0 = rd; r.src1 = rs; end
            5'd3:       begin r.branch = 1'b1; r.we = 1'b1; r.dest = 5'd31; end
            5'd4:       begin r.branch = 1'b1; r.nsrc = 1; r.src0 = rd; end
            5'd5:       begin r.we = 1'b1; r.dest = rd; r.imm = 1'b1; r.nsrc = 1; r.src0 = rs; r.code = 2; end
            5'd7:       begin r.sw = 1'b1; r.imm = 1'b1; r.nsrc = 2; r.src0 = rd; r.src1 = rs; end
            5'd8:       begin r.lw = 1'b1; r.we = 1'b1; r.dest = rd; r.imm = 1'b1; r.nsrc = 1; r.src0 = rs; end
            5'd21:      begin r.we = 1'b1; r.dest = 5'd30; end
            5'd22:      begin r.branch = 1'b1; r.nsrc = 1; r.src0 = 5'd30; end
            default: ;
        endcase
        if (r.dest == 5'd0) r.we = 1'b0;
        return r;
    endfunction

    function automatic bit reads(input instr_t i, input bit [4:0] r);
        return (i.nsrc >= 1 && i.src0 == r) || (i.nsrc >= 2 && i.src1 == r);
    endfunction

    function automatic logic [63:0] all_outs();
        return {10'd0, stall, md_start, md_is_div, ex_valid, ex_alu_imm, ex_md, ex_aluop,
                mem_valid, mem_we, wb_valid, wb_we, wb_sel_mem, wb_rd, wb_status_we, wb_status};
    endfunction

    task automatic model_reset();
        m_ex = none(); m_mem = none(); m_wb = none();
        m_mem_exc = 1'b0; m_wb_exc = 1'b0; m_started = 1'b0; m_last_stall = 1'b0;
    endtask

    // Compare every DUT output against the model for the current cycle, then step the model.
    task automatic compare_and_step();
        bit hold, lu, exc;
        hold = m_ex.valid && m_ex.md && !md_ready;
        lu   = cur_id.valid && m_ex.valid && m_ex.lw && m_ex.we && reads(cur_id, m_ex.dest);
        m_last_stall = hold || (lu && !br_taken);
        check("stall", stall, m_last_stall);
        check("md_start", md_start, m_ex.valid && m_ex.md && !m_started);
        check("md_is_div", md_is_div, m_ex.valid && m_ex.md && !m_started && m_ex.div);
        check("ex_valid", ex_valid, m_ex.valid);
        check("ex_alu_imm", ex_alu_imm, m_ex.imm);
        check("ex_md", ex_md, m_ex.md);
        check("ex_aluop", ex_aluop, m_ex.aluop);
        check("mem_valid", mem_valid, m_mem.valid);
        check("mem_we", mem_we, m_mem.sw);
        check("wb_valid", wb_valid, m_wb.valid);
        check("wb_we", wb_we, m_wb.we && !m_wb_exc);
        check("wb_sel_mem", wb_sel_mem, m_wb.lw);
        check("wb_rd", wb_rd, m_wb_exc ? 5'd30 : (m_wb.we ? m_wb.dest : 5'd0));
        check("wb_status_we", wb_status_we, m_wb_exc);
        check("wb_status", wb_status, m_wb_exc ? 32'(m_wb.code) : 32'd0);

        exc = m_ex.valid && (m_ex.code != 0) && (m_ex.md ? md_exc : alu_ovf);
        m_wb     = m_mem;
        m_wb_exc = m_mem_exc;
        if (hold) begin
            m_mem     = none();
            m_mem_exc = 1'b0;
        end else begin
            m_mem     = m_ex;
            m_mem_exc = exc;
            m_ex      = (br_taken || lu) ? none() : cur_id;
        end
        m_started = hold;
    endtask

    // One clock cycle: drive inputs just after the falling edge, sample 1 ns later.
    task automatic cyc(input bit v, input bit [4:0] op, input bit [4:0] alu, input bit [4:0] rd,
                       input bit [4:0] rs, input bit [4:0] rt, input bit br, input bit ovf,
                       input bit rdy, input bit exc);
        @(negedge clk);
        id_valid = v; id_opcode = op; id_aluop = alu; id_rd = rd; id_rs = rs; id_rt = rt;
        br_taken = br; alu_ovf = ovf; md_ready = rdy; md_exc = exc;
        cur_id = decode(v, op, alu, rd, rs, rt);
        #1;
        compare_and_step();
    endtask

    task automatic idle(input bit rdy = 1'b0, input bit exc = 1'b0, input bit ovf = 1'b0);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, ovf, rdy, exc);
    endtask

    initial begin
        int stall_cnt;
        bit       r_v;
        bit [4:0] r_op, r_alu, r_rd, r_rs, r_rt;

        rst_n = 1'b0;
        id_valid = 1'b0; id_opcode = '0; id_aluop = '0; id_rd = '0; id_rs = '0; id_rt = '0;
        br_taken = 1'b0; alu_ovf = 1'b0; md_ready = 1'b0; md_exc = 1'b0;
        model_reset();
        #2;
        check("reset_outputs_zero", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two independent adds: WB three cycles after decode, back to back.
        cyc(1, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd2, 5'd4, 5'd5, 0, 0, 0, 0);
        check("add_no_stall", stall, 1'b0);
        idle();
        idle();
        check("add1_wb_valid", wb_valid, 1'b1);
        check("add1_wb_rd", wb_rd, 5'd1);
        idle();
        check("add2_wb_valid", wb_valid, 1'b1);
        check("add2_wb_rd", wb_rd, 5'd2);

        // Load-use: lw r5 then add r6 = r5 + r7.
        cyc(1, 5'd8, 5'd0, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd6, 5'd5, 5'd7, 0, 0, 0, 0);
        check("lu_stall", stall, 1'b1);
        cyc(1, 5'd0, 5'd0, 5'd6, 5'd5, 5'd7, 0, 0, 0, 0);
        check("lu_stall_one_cycle", stall, 1'b0);
        check("lu_bubble", ex_valid, 1'b0);
        idle();
        check("lu_add_in_ex", ex_valid, 1'b1);
        // Same pair with the load targeting r0: no hazard.
        cyc(1, 5'd8, 5'd0, 5'd0, 5'd1, 5'd0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd6, 5'd0, 5'd7, 0, 0, 0, 0);
        check("lu_r0_no_stall", stall, 1'b0);
        idle();
        check("lu_r0_no_bubble", ex_valid, 1'b1);

        // mul with md_ready held off for four cycles.
        cyc(1, 5'd0, 5'd6, 5'd9, 5'd1, 5'd2, 0, 0, 0, 0);
        stall_cnt = 0;
        idle();
        check("mul_start", md_start, 1'b1);
        check("mul_is_div", md_is_div, 1'b0);
        stall_cnt += int'(stall);
        for (int k = 0; k < 3; k++) begin
            idle();
            check("mul_no_repulse", md_start, 1'b0);
            stall_cnt += int'(stall);
        end
        idle(1'b1, 1'b0);
        stall_cnt += int'(stall);
        check("mul_stall_cycles", 64'(stall_cnt), 64'd4);
        idle();
        idle();
        check("mul_wb_valid", wb_valid, 1'b1);
        check("mul_wb_rd", wb_rd, 5'd9);
        check("mul_wb_we", wb_we, 1'b1);

        // Exceptions: addi overflow, div exception, writes to r0, setx.
        cyc(1, 5'd5, 5'd0, 5'd4, 5'd1, 5'd0, 0, 0, 0, 0);
        idle(1'b0, 1'b0, 1'b1);
        idle();
        idle();
        check("addi_ovf_status_we", wb_status_we, 1'b1);
        check("addi_ovf_rd", wb_rd, 5'd30);
        check("addi_ovf_status", wb_status, 32'd2);
        check("addi_ovf_no_we", wb_we, 1'b0);
        cyc(1, 5'd0, 5'd7, 5'd8, 5'd1, 5'd2, 0, 0, 0, 0);
        idle(1'b1, 1'b1);
        check("div_start", md_start, 1'b1);
        check("div_is_div", md_is_div, 1'b1);
        check("div_one_cycle_no_stall", stall, 1'b0);
        idle();
        idle();
        check("div_exc_status", wb_status, 32'd5);
        check("div_exc_status_we", wb_status_we, 1'b1);
        cyc(1, 5'd5, 5'd0, 5'd0, 5'd1, 5'd0, 0, 0, 0, 0);
        idle();
        idle();
        idle();
        check("r0_wb_valid", wb_valid, 1'b1);
        check("r0_wb_we", wb_we, 1'b0);
        cyc(1, 5'd21, 5'd0, 5'd3, 5'd0, 5'd0, 0, 0, 0, 0);
        idle(1'b0, 1'b0, 1'b1);
        idle();
        idle();
        check("setx_wb_rd", wb_rd, 5'd30);
        check("setx_wb_we", wb_we, 1'b1);
        check("setx_no_status_we", wb_status_we, 1'b0);

        // Flush: taken bne kills the lw behind it; taken branch overrides a load-use stall.
        cyc(1, 5'd2, 5'd0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0);
        cyc(1, 5'd8, 5'd0, 5'd5, 5'd3, 5'd0, 1, 0, 0, 0);
        check("flush_no_stall", stall, 1'b0);
        idle();
        check("flush_bubble", ex_valid, 1'b0);
        cyc(1, 5'd8, 5'd0, 5'd5, 5'd1, 5'd0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd6, 5'd5, 5'd7, 1, 0, 0, 0);
        check("flush_over_lu_no_stall", stall, 1'b0);
        idle();
        check("flush_over_lu_bubble", ex_valid, 1'b0);

        // Reset asserted while the mul/div unit is busy.
        cyc(1, 5'd0, 5'd6, 5'd9, 5'd1, 5'd2, 0, 0, 0, 0);
        idle();
        idle();
        check("busy_before_reset", stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy_outputs_zero", all_outs(), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1, 1'b0);
        check("late_ready_no_start", md_start, 1'b0);
        check("late_ready_no_stall", stall, 1'b0);

        // Randomized traffic; ID is held whenever the model says the pipe stalled.
        r_v = 1'b0; r_op = '0; r_alu = '0; r_rd = '0; r_rs = '0; r_rt = '0;
        for (int i = 0; i < 3000; i++) begin
            bit br, rdy;
            if (!m_last_stall) begin
                r_v = ($urandom_range(0, 5) != 0);
                case ($urandom_range(0, 13))
                    0, 1, 2: r_op = 5'd0;
                    3:       r_op = 5'd1;
                    4:       r_op = 5'd2;
                    5:       r_op = 5'd3;
                    6:       r_op = 5'd4;
                    7:       r_op = 5'd5;
                    8:       r_op = 5'd6;
                    9:       r_op = 5'd7;
                    10, 11:  r_op = 5'd8;
                    12:      r_op = ($urandom_range(0, 1) != 0) ? 5'd21 : 5'd22;
                    default: r_op = 5'($urandom_range(0, 31));
                endcase
                case ($urandom_range(0, 4))
                    0:       r_alu = 5'd0;
                    1:       r_alu = 5'd1;
                    2:       r_alu = 5'd6;
                    3:       r_alu = 5'd7;
                    default: r_alu = 5'($urandom_range(0, 31));
                endcase
                r_rd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(30, 31)) : 5'($urandom_range(0, 7));
                r_rs = 5'($urandom_range(0, 7));
                r_rt = 5'($urandom_range(0, 7));
            end
            br  = m_ex.valid && m_ex.branch && ($urandom_range(0, 2) == 0);
            rdy = m_ex.valid && m_ex.md && ($urandom_range(0, 2) == 0);
            cyc(r_v, r_op, r_alu, r_rd, r_rs, r_rt, br, ($urandom_range(0, 3) == 0), rdy,
                ($urandom_range(0, 1) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
